// File: rtl/piso_serializer_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and counter sizing.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

  // Counter must be able to hold DATA_WIDTH itself so it never wraps in a frame.
  function automatic int unsigned cnt_width(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Enable-gated bit counter with synchronous clear and terminal-count flag.
module piso_bit_cnt #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LAST  = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == WIDTH'(LAST));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load and serial links.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter bit          SHIFT_LEFT = 1'b1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] par_in,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  serial_out,
  output logic                  serial_valid,
  input  logic                  serial_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

  piso_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  load_ready_q;
  logic                  done_q;
  logic                  ld, cnt_en, last_acc, cnt_tc;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  piso_bit_cnt #(
    .WIDTH (CNT_W),
    .LAST  (DATA_WIDTH - 1)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ld),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    ld       = 1'b0;
    cnt_en   = 1'b0;
    last_acc = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid && load_ready_q) begin
          ld      = 1'b1;
          shreg_d = par_in;
          state_d = SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
          parity_d = ^par_in;
`endif
        end
      end
      SHIFT: begin
        if (serial_ready) begin
          cnt_en  = 1'b1;
          shreg_d = SHIFT_LEFT ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[DATA_WIDTH-1:1]};
          if (cnt_tc) begin
`ifdef PISO_SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            state_d  = IDLE;
            last_acc = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (serial_ready) begin
          state_d  = IDLE;
          last_acc = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // load_ready is registered from the next state so it stays low while rst is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      load_ready_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      load_ready_q <= (state_d == IDLE);
      done_q       <= last_acc;
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    serial_out = 1'b0;
    case (state_q)
      SHIFT:   serial_out = SHIFT_LEFT ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY:  serial_out = parity_q;
`endif
      default: serial_out = 1'b0;
    endcase
  end

  assign serial_valid = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign load_ready   = load_ready_q;
  assign done         = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed + randomized bench for piso_serializer: MSB-first and LSB-first instances side by side.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int unsigned NBITS = 9;
`else
  localparam int unsigned NBITS = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] par_in;
  logic       load_valid;
  logic       serial_ready;
  logic       load_ready_l, serial_out_l, serial_valid_l, busy_l, done_l;
  logic       load_ready_r, serial_out_r, serial_valid_r, busy_r, done_r;

  int n_chk  = 0;
  int n_fail = 0;

  piso_serializer #(.SHIFT_LEFT(1'b1), .DATA_WIDTH(8)) u_msb (
    .clk          (clk),
    .rst          (rst),
    .par_in       (par_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready_l),
    .serial_out   (serial_out_l),
    .serial_valid (serial_valid_l),
    .serial_ready (serial_ready),
    .busy         (busy_l),
    .done         (done_l)
  );

  piso_serializer #(.SHIFT_LEFT(1'b0), .DATA_WIDTH(8)) u_lsb (
    .clk          (clk),
    .rst          (rst),
    .par_in       (par_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready_r),
    .serial_out   (serial_out_r),
    .serial_valid (serial_valid_r),
    .serial_ready (serial_ready),
    .busy         (busy_r),
    .done         (done_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bit idx of the frame for word w; index 8 is the even-parity bit.
  function automatic logic exp_bit(input logic [7:0] w, input int unsigned idx, input bit msb_first);
    if (idx >= 8) return ^w;
    return msb_first ? w[7 - idx] : w[idx];
  endfunction

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_done_l"},  done_l,         exp_done);
    chk({tag, "_done_r"},  done_r,         exp_done);
    chk({tag, "_busy_l"},  busy_l,         1'b0);
    chk({tag, "_valid_r"}, serial_valid_r, 1'b0);
    chk({tag, "_sout_l"},  serial_out_l,   1'b0);
    chk({tag, "_lrdy_l"},  load_ready_l,   1'b1);
    chk({tag, "_lrdy_r"},  load_ready_r,   1'b1);
  endtask

  // mode 0: always ready; 1: hold bit 3 for 5 cycles; 2: random stalls.
  task automatic send(input logic [7:0] w, input int unsigned mode);
    int unsigned idx, cycles, stalls;
    logic [7:0]  rec_l, rec_r;
    logic        r;
    chk("load_ready_l", load_ready_l, 1'b1);
    chk("load_ready_r", load_ready_r, 1'b1);
    par_in       = w;
    load_valid   = 1'b1;
    serial_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    idx = 0; cycles = 0; stalls = 0; rec_l = '0; rec_r = '0;
    while (idx < NBITS && cycles < 100) begin
      chk($sformatf("w%02h_bit%0d_l", w, idx), serial_out_l, exp_bit(w, idx, 1'b1));
      chk($sformatf("w%02h_bit%0d_r", w, idx), serial_out_r, exp_bit(w, idx, 1'b0));
      chk("frame_valid_l", serial_valid_l, 1'b1);
      chk("frame_busy_r",  busy_r,         1'b1);
      chk("frame_done_l",  done_l,         1'b0);
      chk("frame_lrdy_r",  load_ready_r,   1'b0);
      load_valid = 1'($urandom_range(0, 1));
      par_in     = 8'($urandom);
      case (mode)
        0:       r = 1'b1;
        1:       r = !(idx == 3 && stalls < 5);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      serial_ready = r;
      if (!r) stalls++;
      if (r) begin
        if (idx < 8) begin
          rec_l = {rec_l[6:0], serial_out_l};
          rec_r = {serial_out_r, rec_r[7:1]};
        end
        idx++;
      end
      cycles++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    chk("frame_timeout", idx, NBITS);
    chk("frame_cycles", cycles, NBITS + stalls);
    if (mode == 1) chk("stall_frame_len", cycles, NBITS + 5);
    chk("sipo_rec_l", rec_l, w);
    chk("sipo_rec_r", rec_r, w);
    chk_idle("end", 1'b1);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; load_valid = 1'b0; serial_ready = 1'b0; par_in = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_valid_l", serial_valid_l, 1'b0);
      chk("rst_busy_r",  busy_r,         1'b0);
      chk("rst_done_l",  done_l,         1'b0);
      chk("rst_lrdy_l",  load_ready_l,   1'b0);
      chk("rst_sout_r",  serial_out_r,   1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_rst", 1'b0);

    send(8'hC1, 0);
    @(negedge clk);
    chk_idle("after_c1", 1'b0);

    send(8'hC1, 1);
    @(negedge clk);
    chk_idle("after_stall", 1'b0);

    send(8'hC1, 0);
    send(8'h3E, 0);
    send(8'hC3, 0);
    @(negedge clk);
    chk_idle("after_b2b", 1'b0);

    for (int k = 0; k < 12; k++) begin
      w = 8'($urandom);
      send(w, 2);
      if (k % 3 == 0) begin
        @(negedge clk);
        chk_idle("rand_gap", 1'b0);
      end
    end

    // Abort a frame with reset after three accepted bits.
    par_in = 8'hA5; load_valid = 1'b1; serial_ready = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy_l", busy_l, 1'b1);
    chk("pre_abort_bit3_l", serial_out_l, exp_bit(8'hA5, 3, 1'b1));
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_valid_l", serial_valid_l, 1'b0);
      chk("abort_busy_r",  busy_r,         1'b0);
      chk("abort_done_l",  done_l,         1'b0);
      chk("abort_done_r",  done_r,         1'b0);
      chk("abort_lrdy_l",  load_ready_l,   1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk_idle("abort_release", 1'b0);
    @(negedge clk);
    chk_idle("abort_quiet", 1'b0);

    send(8'h5A, 2);
    @(negedge clk);
    chk_idle("final", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
